// File: rtl/boot_pkg.sv
// Shared types and constants for the boot flash-to-SRAM copier.
// Holds the FSM encoding, bus widths and fixed flash pin levels.
package boot_pkg;

  localparam int FLASH_AW = 23;
  localparam int WIDX_W   = 22;
  localparam int RAM_AW   = 18;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 4;

  localparam logic PIN_BYTE = 1'b1;
  localparam logic PIN_VPEN = 1'b1;
  localparam logic PIN_RP   = 1'b1;
  localparam logic PIN_WE   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/flash_word_reader.sv
// Single-word NOR flash read timing: start loads address and drops ce/oe,
// valid marks the last wait cycle, capture samples data and releases oe.
module flash_word_reader
  import boot_pkg::*;
#(
  parameter int WAIT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDX_W-1:0]   word_idx,
  input  logic                capture,
  input  logic [DATA_W-1:0]   flash_data_in,
  output logic [FLASH_AW-1:0] flash_addr,
  output logic                flash_ce,
  output logic                flash_oe,
  output logic                valid,
  output logic [DATA_W-1:0]   data
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             waiting;

  assign valid = waiting && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_addr <= '0;
      flash_ce   <= 1'b1;
      flash_oe   <= 1'b1;
      cnt        <= '0;
      waiting    <= 1'b0;
      data       <= '0;
    end else begin
      if (start) begin
        flash_addr <= {word_idx, 1'b0};
        flash_ce   <= 1'b0;
        flash_oe   <= 1'b0;
        cnt        <= WAIT_LOAD;
        waiting    <= 1'b1;
      end else if (waiting) begin
        if (cnt == '0) begin
          waiting <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      // sample on the same edge that deasserts oe
      if (capture) begin
        data     <= flash_data_in;
        flash_ce <= 1'b1;
        flash_oe <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/boot_copier.sv
// Copies WORDS flash words into SRAM after reset, holding the CPU in
// reset until done. Ports: flash pins, SRAM req/ack port, cpu_hold/done.
module boot_copier
  import boot_pkg::*;
#(
  parameter logic [21:0] FLASH_BASE  = 22'h000000,
  parameter logic [17:0] RAM_BASE    = 18'h00000,
  parameter logic [15:0] WORDS       = 16'h0800,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [FLASH_AW-1:0] flash_addr,
  input  logic [DATA_W-1:0]   flash_data_in,
  output logic                flash_byte,
  output logic                flash_vpen,
  output logic                flash_rp,
  output logic                flash_ce,
  output logic                flash_oe,
  output logic                flash_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_wr_req,
  input  logic                ram_wr_ack,
  output logic                cpu_hold,
  output logic                done,
  output logic [15:0]         progress
);

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       idx;
  logic [WIDX_W-1:0] word_idx;
  logic              rd_start;
  logic              rd_capture;
  logic              rd_valid;

  assign flash_byte = PIN_BYTE;
  assign flash_vpen = PIN_VPEN;
  assign flash_rp   = PIN_RP;
  assign flash_we   = PIN_WE;

  // flash index wraps silently at 2^22
  assign word_idx   = FLASH_BASE + WIDX_W'(idx);
  assign rd_start   = (state == S_SETUP);
  assign rd_capture = (state == S_LATCH);

  assign ram_wr_req = (state == S_WRITE);
  assign done       = (state == S_DONE);
  assign cpu_hold   = (state != S_DONE);

  flash_word_reader #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_reader (
    .clk           (clk),
    .rst           (rst),
    .start         (rd_start),
    .word_idx      (word_idx),
    .capture       (rd_capture),
    .flash_data_in (flash_data_in),
    .flash_addr    (flash_addr),
    .flash_ce      (flash_ce),
    .flash_oe      (flash_oe),
    .valid         (rd_valid),
    .data          (ram_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = (WORDS == '0) ? S_DONE : S_SETUP;
      S_SETUP: state_nxt = S_WAIT;
      S_WAIT:  if (rd_valid) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_WRITE;
      S_WRITE: if (ram_wr_ack) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (progress == WORDS) ? S_DONE : S_SETUP;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      progress <= '0;
      ram_addr <= '0;
    end else begin
      if (state == S_IDLE) begin
        idx <= '0;
      end
      if (state == S_NEXT && progress != WORDS) begin
        idx <= idx + 16'd1;
      end
      if (state == S_LATCH) begin
        ram_addr <= RAM_BASE + RAM_AW'(idx);
      end
      if (state == S_WRITE && ram_wr_ack) begin
        progress <= progress + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_boot_copier.sv
// Directed bench for boot_copier: basic copy, ack stall, WORDS=0,
// mid-copy reset and address wrap, with immediate-assertion checks.
module tb_boot_copier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT a: WORDS=4, WAIT=4, base 0
  logic        rst_a;
  logic [22:0] fa_a;
  logic [15:0] fd_a;
  logic        byte_a, vpen_a, rp_a, ce_a, oe_a, we_a;
  logic [17:0] radr_a;
  logic [15:0] wd_a;
  logic        req_a, ack_a, hold_a, done_a;
  logic [15:0] prog_a;
  logic        ack_en;

  assign fd_a  = 16'hA000 + {7'b0, fa_a[9:1]};
  assign ack_a = req_a & ack_en;

  boot_copier #(
    .FLASH_BASE (22'h000000),
    .RAM_BASE   (18'h00000),
    .WORDS      (16'd4),
    .WAIT_CYCLES(4)
  ) u_a (
    .clk(clk), .rst(rst_a), .flash_addr(fa_a), .flash_data_in(fd_a),
    .flash_byte(byte_a), .flash_vpen(vpen_a), .flash_rp(rp_a),
    .flash_ce(ce_a), .flash_oe(oe_a), .flash_we(we_a),
    .ram_addr(radr_a), .ram_wdata(wd_a), .ram_wr_req(req_a),
    .ram_wr_ack(ack_a), .cpu_hold(hold_a), .done(done_a),
    .progress(prog_a)
  );

  // DUT w: address wrap, WAIT=2
  logic        rst_w;
  logic [22:0] fa_w;
  logic [15:0] fd_w;
  logic        byte_w, vpen_w, rp_w, ce_w, oe_w, we_w;
  logic [17:0] radr_w;
  logic [15:0] wd_w;
  logic        req_w, hold_w, done_w;
  logic [15:0] prog_w;

  assign fd_w = 16'hC000 | {12'h0, fa_w[4:1]};

  boot_copier #(
    .FLASH_BASE (22'h3FFFFE),
    .RAM_BASE   (18'h3FFFF),
    .WORDS      (16'd3),
    .WAIT_CYCLES(2)
  ) u_w (
    .clk(clk), .rst(rst_w), .flash_addr(fa_w), .flash_data_in(fd_w),
    .flash_byte(byte_w), .flash_vpen(vpen_w), .flash_rp(rp_w),
    .flash_ce(ce_w), .flash_oe(oe_w), .flash_we(we_w),
    .ram_addr(radr_w), .ram_wdata(wd_w), .ram_wr_req(req_w),
    .ram_wr_ack(req_w), .cpu_hold(hold_w), .done(done_w),
    .progress(prog_w)
  );

  // DUT z: WORDS=0
  logic        rst_z;
  logic [22:0] fa_z;
  logic        byte_z, vpen_z, rp_z, ce_z, oe_z, we_z;
  logic [17:0] radr_z;
  logic [15:0] wd_z;
  logic        req_z, hold_z, done_z;
  logic [15:0] prog_z;

  boot_copier #(
    .WORDS      (16'd0),
    .WAIT_CYCLES(4)
  ) u_z (
    .clk(clk), .rst(rst_z), .flash_addr(fa_z), .flash_data_in(16'h0),
    .flash_byte(byte_z), .flash_vpen(vpen_z), .flash_rp(rp_z),
    .flash_ce(ce_z), .flash_oe(oe_z), .flash_we(we_z),
    .ram_addr(radr_z), .ram_wdata(wd_z), .ram_wr_req(req_z),
    .ram_wr_ack(req_z), .cpu_hold(hold_z), .done(done_z),
    .progress(prog_z)
  );

  // monitors, sampled on the falling edge
  logic [22:0] fall_a[$];
  int          ftime_a[$];
  int          oel_a[$];
  int          reql_a[$];
  logic [17:0] wadr_a[$];
  logic [15:0] wdat_a[$];
  logic        oe_pa = 1'b1;
  logic        req_pa = 1'b0;
  logic [17:0] padr_a = '0;
  logic [15:0] pdat_a = '0;
  int          oelen_a = 0;
  int          reqlen_a = 0;
  int          unstable_a = 0;

  always @(negedge clk) begin
    if (!oe_a && oe_pa) begin
      fall_a.push_back(fa_a);
      ftime_a.push_back(cyc);
    end
    if (!oe_a) oelen_a <= oelen_a + 1;
    else if (!oe_pa) begin
      oel_a.push_back(oelen_a);
      oelen_a <= 0;
    end
    if (req_a && ack_a) begin
      wadr_a.push_back(radr_a);
      wdat_a.push_back(wd_a);
    end
    if (req_a && req_pa && (radr_a != padr_a || wd_a != pdat_a))
      unstable_a <= unstable_a + 1;
    if (req_a) reqlen_a <= reqlen_a + 1;
    else if (req_pa) begin
      reql_a.push_back(reqlen_a);
      reqlen_a <= 0;
    end
    oe_pa  <= oe_a;
    req_pa <= req_a;
    padr_a <= radr_a;
    pdat_a <= wd_a;
  end

  logic [22:0] fall_w[$];
  int          oel_w[$];
  logic [17:0] wadr_w[$];
  logic [15:0] wdat_w[$];
  logic        oe_pw = 1'b1;
  int          oelen_w = 0;

  always @(negedge clk) begin
    if (!oe_w && oe_pw) fall_w.push_back(fa_w);
    if (!oe_w) oelen_w <= oelen_w + 1;
    else if (!oe_pw) begin
      oel_w.push_back(oelen_w);
      oelen_w <= 0;
    end
    if (req_w) begin
      wadr_w.push_back(radr_w);
      wdat_w.push_back(wd_w);
    end
    oe_pw <= oe_w;
  end

  logic ever_oe_z = 1'b0;
  logic ever_req_z = 1'b0;
  always @(negedge clk) begin
    if (!oe_z) ever_oe_z <= 1'b1;
    if (req_z) ever_req_z <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_nwr"}, 32'(wadr_a.size()), 32'd4);
    chk({tag, "_nrd"}, 32'(fall_a.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_faddr"}, 32'(fall_a[i]), 32'(2 * i));
      chk({tag, "_raddr"}, 32'(wadr_a[i]), 32'(i));
      chk({tag, "_wdata"}, 32'(wdat_a[i]), 32'h0000A000 + 32'(i));
      chk({tag, "_oelen"}, 32'(oel_a[i]), 32'd5);
    end
    chk({tag, "_done"}, 32'(done_a), 32'd1);
    chk({tag, "_hold"}, 32'(hold_a), 32'd0);
    chk({tag, "_prog"}, 32'(prog_a), 32'd4);
    chk({tag, "_cexoe"}, 32'({ce_a, oe_a, req_a}), 32'b110);
  endtask

  task automatic clear_a();
    fall_a.delete();
    ftime_a.delete();
    oel_a.delete();
    reql_a.delete();
    wadr_a.delete();
    wdat_a.delete();
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    n = 0;
    while (!done_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(done_a), 32'd1);
  endtask

  logic [22:0] ew_fa [3] = '{23'h7FFFFC, 23'h7FFFFE, 23'h000000};
  logic [17:0] ew_ra [3] = '{18'h3FFFF, 18'h00000, 18'h00001};
  logic [15:0] ew_wd [3] = '{16'hC00E, 16'hC00F, 16'hC000};

  initial begin
    int n;
    rst_a  = 1'b0;
    rst_w  = 1'b0;
    rst_z  = 1'b0;
    ack_en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    chk("rst_hold", 32'(hold_a), 32'd1);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_req", 32'(req_a), 32'd0);
    chk("rst_ceoe", 32'({ce_a, oe_a}), 32'b11);
    chk("rst_pins", 32'({byte_a, vpen_a, rp_a, we_a}), 32'hF);
    chk("rst_prog", 32'(prog_a), 32'd0);
    chk("rst_faddr", 32'(fa_a), 32'd0);
    chk("rst_ram", 32'({radr_a, wd_a}), 32'd0);

    rst_a = 1'b1;
    rst_w = 1'b1;
    rst_z = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk("z_done", 32'(done_z), 32'd1);
        chk("z_hold", 32'(hold_z), 32'd0);
      end
    end while (!done_a && n < 200);
    chk("basic_latency", 32'(n), 32'd33);
    @(negedge clk);
    check_words("basic");
    for (int i = 1; i < 4; i++)
      chk("basic_wordcyc", 32'(ftime_a[i] - ftime_a[i-1]), 32'd8);
    for (int i = 0; i < 4; i++)
      chk("basic_reqlen", 32'(reql_a[i]), 32'd1);

    chk("wrap_done", 32'(done_w), 32'd1);
    chk("wrap_nwr", 32'(wadr_w.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_faddr", 32'(fall_w[i]), 32'(ew_fa[i]));
      chk("wrap_raddr", 32'(wadr_w[i]), 32'(ew_ra[i]));
      chk("wrap_wdata", 32'(wdat_w[i]), 32'(ew_wd[i]));
      chk("wrap_oelen", 32'(oel_w[i]), 32'd3);
    end

    chk("z_no_oe", 32'(ever_oe_z), 32'd0);
    chk("z_no_req", 32'(ever_req_z), 32'd0);
    chk("z_pins", 32'({byte_z, vpen_z, rp_z, we_z}), 32'hF);

    // ack held off for three extra cycles on word 1
    rst_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_a();
    rst_a = 1'b1;
    n = 0;
    while (prog_a != 16'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_prog1", 32'(prog_a), 32'd1);
    ack_en = 1'b0;
    n = 0;
    while (!req_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_req", 32'(req_a), 32'd1);
    repeat (3) @(posedge clk);
    #1 ack_en = 1'b1;
    wait_done_a("stall");
    @(negedge clk);
    check_words("stall");
    chk("stall_reqlen0", 32'(reql_a[0]), 32'd1);
    chk("stall_reqlen1", 32'(reql_a[1]), 32'd4);
    chk("stall_reqlen2", 32'(reql_a[2]), 32'd1);
    chk("stall_stable", 32'(unstable_a), 32'd0);

    // reset during the wait phase of word 2
    rst_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_a();
    rst_a = 1'b1;
    n = 0;
    while (prog_a != 16'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_prog2", 32'(prog_a), 32'd2);
    n = 0;
    while (oe_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_oelow", 32'(oe_a), 32'd0);
    chk("mid_faddr_w2", 32'(fa_a), 32'd4);
    #2 rst_a = 1'b0;
    #1;
    chk("mid_ceoe", 32'({ce_a, oe_a}), 32'b11);
    chk("mid_faddr", 32'(fa_a), 32'd0);
    chk("mid_prog", 32'(prog_a), 32'd0);
    chk("mid_hold", 32'({hold_a, done_a, req_a}), 32'b100);
    @(negedge clk);
    #1 clear_a();
    @(negedge clk);
    rst_a = 1'b1;
    wait_done_a("mid");
    @(negedge clk);
    check_words("mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
